pool_out_framer: RTL and testbench

- Sits directly downstream of the pooling engine's master AXIS output and buffers the pooled feature-map words before the DMA/next layer.
- Regenerates TLAST from the layer configuration: pooled side is Flen/2, with num_INCH channels packed as 4 int8 values per 32-bit word.
- Checks the upstream frame length and provides a done pulse and a word count for the APB status path.

---
 rtl/pool_out_framer.sv | 216 +++++++++++++++++++++
 tb/tb_pool_out_framer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_out_framer.sv
`default_nettype none
// ============================================================================
//  Module   : pool_out_framer
//  Purpose  : Buffers pooled feature-map words from the pooling engine in a
//             small FIFO, regenerates TLAST from the layer configuration
//             ((Flen/2)^2 * num_INCH/4 words), checks the upstream frame
//             length and reports completion for the status path.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, Flen,        - frame start pulse and layer geometry
//             num_INCH
//             S_AXIS_*            - slave stream from the pool stage
//                                   (TKEEP/TUSER ignored, TLAST checked only)
//             M_AXIS_*            - master stream toward DMA / next layer
//             done, busy          - frame completion pulse / activity flag
//             err_len             - sticky upstream frame-length mismatch
//             word_count          - words emitted in the current/last frame
//  Revision : 1.0 - initial release
// ============================================================================
module pool_out_framer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [5:0]                          Flen,
  input  logic [8:0]                          num_INCH,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                                S_AXIS_TUSER,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TUSER,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  output logic                                done,
  output logic                                busy,
  output logic                                err_len,
  output logic [17:0]                         word_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_DW = C_S00_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame bookkeeping
  logic [17:0]     r_total;
  logic [17:0]     r_in_cnt;
  logic [17:0]     r_out_cnt;
  logic            r_err_len;

  // FIFO storage and pointers
  logic [c_DW-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic [17:0]     w_total_calc;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_last_in;
  logic            w_last_out;
  logic            w_start_acc;
  logic            w_unused;

  // Odd Flen truncates and the low channel bits are dropped by taking only
  // the upper bits of each operand.
  assign w_total_calc = 18'(Flen[5:1]) * 18'(Flen[5:1]) * 18'(num_INCH[8:2]);

  assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_last_in  = (r_in_cnt  == r_total - 18'd1);
  assign w_last_out = (r_out_cnt == r_total - 18'd1);

  // Input ready depends only on the current occupancy, never on a pop in
  // the same cycle, so there is no combinational path from M_AXIS_TREADY.
  assign S_AXIS_TREADY = (r_state == ST_RUN) && !w_full;
  assign w_push        = S_AXIS_TREADY && S_AXIS_TVALID;

  assign M_AXIS_TVALID = !w_empty;
  assign w_pop         = M_AXIS_TVALID && M_AXIS_TREADY;
  // Forced to zero while empty so the idle/reset value is defined even
  // though the storage array itself is never cleared.
  assign M_AXIS_TDATA  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign M_AXIS_TLAST  = !w_empty && w_last_out;
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TUSER  = 1'b0;

  assign err_len    = r_err_len;
  assign word_count = r_out_cnt;

  assign w_unused = &{1'b0, S_AXIS_TKEEP, S_AXIS_TUSER, Flen[0], num_INCH[1:0]};

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (w_total_calc != 18'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_push && w_last_in) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_pop && M_AXIS_TLAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame counters and length checker
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_err_len <= 1'b0;
    end else if (w_start_acc) begin
      r_total   <= w_total_calc;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_err_len <= 1'b0;
    end else begin
      if (w_push) begin
        r_in_cnt <= r_in_cnt + 18'd1;
        // Upstream TLAST must coincide exactly with the last expected word.
        if (S_AXIS_TLAST != w_last_in) begin
          r_err_len <= 1'b1;
        end
      end
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + 18'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy (depth is a power of two, pointers wrap)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= S_AXIS_TDATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_out_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_out_framer
//  Purpose  : Self-checking bench for pool_out_framer. A driver pushes the
//             expected {TLAST, TDATA} pair into a scoreboard queue on each
//             input handshake; a monitor pops and compares on each output
//             handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pool_out_framer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  Flen;
  logic [8:0]  num_INCH;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        done;
  logic        busy;
  logic        err_len;
  logic [17:0] word_count;

  pool_out_framer #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .FIFO_DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Flen         (Flen),
    .num_INCH     (num_INCH),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TKEEP (s_tkeep),
    .S_AXIS_TUSER (s_tuser),
    .S_AXIS_TLAST (s_tlast),
    .S_AXIS_TVALID(s_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TUSER (m_tuser),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TKEEP (m_tkeep),
    .M_AXIS_TLAST (m_tlast),
    .M_AXIS_TVALID(m_tvalid),
    .done         (done),
    .busy         (busy),
    .err_len      (err_len),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total_cnt;
  int          bad_cnt;
  logic [32:0] exp_q [$];
  int          out_words;
  int          tlast_seen;
  int          done_seen;
  int          in_hs;
  bit          abort_tx;
  int          rdy_mode;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output-side monitor: scoreboard pop and compare on every handshake.
  task automatic monitor_loop();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_seen++;
        if (m_tvalid && m_tready) begin
          out_words++;
          if (m_tlast) tlast_seen++;
          total_cnt++;
          if (exp_q.size() == 0) begin
            bad_cnt++;
            $display("FAIL out_unexpected: got data 0x%h last %b, expected no word", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin
              bad_cnt++;
              $display("FAIL out_word: got data 0x%h last %b, expected data 0x%h last %b",
                       m_tdata, m_tlast, e[31:0], e[32]);
            end
          end
        end
      end
    end
  endtask

  // Downstream ready: 0 = held low, 1 = held high, otherwise random.
  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic do_start(input logic [5:0] fl, input logic [8:0] nc);
    @(posedge clk);
    #1;
    start    = 1'b1;
    Flen     = fl;
    num_INCH = nc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input int tlast_idx, input bit rnd);
    int  waited;
    bit  got;
    for (int i = 0; i < n && !abort_tx; i++) begin
      if (rnd) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) begin
          s_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tlast  = (i == tlast_idx);
      waited   = 0;
      got      = 1'b0;
      while (!got && !abort_tx) begin
        @(negedge clk);
        if (s_tready && !rst) begin
          got = 1'b1;
          exp_q.push_back({(i == n - 1), s_tdata});
          in_hs++;
        end
        @(posedge clk);
        #1;
        waited++;
        if (!got && waited > 300) begin
          total_cnt++;
          bad_cnt++;
          $display("FAIL in_timeout: word %0d not accepted within 300 cycles", i);
          abort_tx = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_checks(input int n, input int o0, input int t0, input int d0, input logic exp_err);
    repeat (3) @(negedge clk);
    check("frame_words",  32'(out_words - o0), 32'(n));
    check("frame_tlast",  32'(tlast_seen - t0), (n == 0) ? 32'd0 : 32'd1);
    check("frame_done",   32'(done_seen - d0), 32'd1);
    check("frame_wcount", 32'(word_count), 32'(n));
    check("frame_err",    32'(err_len), 32'(exp_err));
    check("frame_busy",   32'(busy), 32'd0);
    check("frame_queue",  32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_tlast), 32'd0);
    check("rst_m_tdata",  m_tdata, 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_err_len",  32'(err_len), 32'd0);
    check("rst_wcount",   32'(word_count), 32'd0);
  endtask

  initial begin
    int o0, t0, d0, h0, seen_rdy, cnt;
    total_cnt  = 0;
    bad_cnt    = 0;
    out_words  = 0;
    tlast_seen = 0;
    done_seen  = 0;
    in_hs      = 0;
    abort_tx   = 1'b0;
    rdy_mode   = 1;
    rst        = 1'b1;
    start      = 1'b0;
    Flen       = '0;
    num_INCH   = '0;
    s_tdata    = '0;
    s_tkeep    = '1;
    s_tuser    = 1'b0;
    s_tlast    = 1'b0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b0;

    fork
      monitor_loop();
      ready_loop();
      begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 4-word frame, downstream always ready
    o0 = out_words; t0 = tlast_seen; d0 = done_seen;
    do_start(6'd4, 9'd4);
    check("t1_busy", 32'(busy), 32'd1);
    send_frame(4, 32'h1100_0000, 3, 1'b0);
    wait_done(50);
    frame_checks(4, o0, t0, d0, 1'b0);

    // 32-word frame with 40-cycle downstream stall
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    o0 = out_words; t0 = tlast_seen; d0 = done_seen; h0 = in_hs;
    do_start(6'd8, 9'd8);
    fork
      send_frame(32, 32'h2200_0000, 31, 1'b0);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t2_stall_data_a", m_tdata, 32'h2200_0000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t2_pushes",       32'(in_hs - h0), 32'd16);
        check("t2_s_tready",     32'(s_tready), 32'd0);
        check("t2_m_tvalid",     32'(m_tvalid), 32'd1);
        check("t2_stall_data_b", m_tdata, 32'h2200_0000);
        check("t2_stall_tlast",  32'(m_tlast), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    wait_done(200);
    frame_checks(32, o0, t0, d0, 1'b0);

    // Early upstream TLAST on word 2: flagged, frame still runs to 4 words
    o0 = out_words; t0 = tlast_seen; d0 = done_seen; h0 = in_hs;
    do_start(6'd4, 9'd4);
    fork
      send_frame(4, 32'h3300_0000, 1, 1'b0);
      begin
        cnt = 0;
        while (in_hs - h0 < 2 && cnt < 100) begin
          @(negedge clk);
          cnt++;
        end
        @(negedge clk);
        check("t3_err_after_w2", 32'(err_len), 32'd1);
      end
    join
    wait_done(50);
    frame_checks(4, o0, t0, d0, 1'b1);

    // Next start clears err_len
    o0 = out_words; t0 = tlast_seen; d0 = done_seen;
    do_start(6'd4, 9'd4);
    check("t3_err_cleared", 32'(err_len), 32'd0);
    send_frame(4, 32'h3400_0000, 3, 1'b0);
    wait_done(50);
    frame_checks(4, o0, t0, d0, 1'b0);

    // total == 0: no transfer, immediate done
    o0 = out_words; t0 = tlast_seen; d0 = done_seen;
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEAD_BEEF;
    seen_rdy = 0;
    do_start(6'd1, 9'd16);
    check("t4_wcount_cleared", 32'(word_count), 32'd0);
    wait_done(2);
    repeat (4) begin
      @(negedge clk);
      if (s_tready) seen_rdy++;
    end
    s_tvalid = 1'b0;
    check("t4_tready_seen", 32'(seen_rdy), 32'd0);
    frame_checks(0, o0, t0, d0, 1'b0);

    // Reset after 5 output words, then a clean 16-word frame
    o0 = out_words; d0 = done_seen;
    do_start(6'd8, 9'd4);
    fork
      send_frame(16, 32'h5500_0000, 15, 1'b0);
      begin
        cnt = 0;
        while (out_words - o0 < 5 && cnt < 200) begin
          @(negedge clk);
          cnt++;
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        abort_tx = 1'b1;
      end
    join
    @(posedge clk);
    @(negedge clk);
    reset_checks();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    abort_tx = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", 32'(done_seen - d0), 32'd0);
    check("t5_empty",   32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    o0 = out_words; t0 = tlast_seen; d0 = done_seen;
    do_start(6'd8, 9'd4);
    send_frame(16, 32'h5600_0000, 15, 1'b0);
    wait_done(50);
    frame_checks(16, o0, t0, d0, 1'b0);

    // Random handshakes, 27 words, stray start pulses during RUN
    rdy_mode = 2;
    o0 = out_words; t0 = tlast_seen; d0 = done_seen;
    do_start(6'd6, 9'd12);
    fork
      send_frame(27, 32'h6600_0000, 26, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; Flen = 6'd4; num_INCH = 9'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; Flen = 6'd2; num_INCH = 9'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    wait_done(600);
    rdy_mode = 1;
    frame_checks(27, o0, t0, d0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
